// File: rtl/coldata_i2c_pkg.sv
// -----------------------------------------------------------------------------
// coldata_i2c_pkg
// Shared definitions for the coldata_i2c request scheduler:
//   FRAME_W        - width of one engine frame (3 bytes, each followed by an
//                    ack slot, MSB first)
//   ST_*           - response status codes returned to requesters
//   state_t        - scheduler FSM states
//   idx_w()        - width of an index into a requester vector
//   done_status()  - status code for a transaction that the engine completed
// -----------------------------------------------------------------------------
package coldata_i2c_pkg;

  localparam int FRAME_W = 27;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NACK    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  // S_ prefix keeps state names clear of the GAP/TIMEOUT parameters
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  // Index width for an n-entry requester vector (at least one bit)
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Status of a transaction the engine finished (done seen)
  function automatic logic [1:0] done_status(input logic ack_err);
    return ack_err ? ST_NACK : ST_OK;
  endfunction

endpackage

// File: rtl/coldata_i2c_rr_arb.sv
// -----------------------------------------------------------------------------
// coldata_i2c_rr_arb
// Combinational round-robin pick: returns the first asserted request found
// when searching upward from (i_ptr + 1) mod N_REQ, wrapping around.
// Ports:
//   i_req   [N_REQ]  request vector
//   i_ptr   [PTR_W]  index of the most recent grant
//   o_grant [PTR_W]  index of the winning requester (0 when none)
//   o_any            at least one request is asserted
// -----------------------------------------------------------------------------
module coldata_i2c_rr_arb
  import coldata_i2c_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [PTR_W-1:0] o_grant,
  output logic             o_any
);

  // One extra bit so ptr + offset never overflows before the wrap
  localparam int SUM_W = PTR_W + 1;

  logic [SUM_W-1:0] w_sum;
  logic [PTR_W-1:0] w_idx;

  // Priority search; scanning from the farthest offset down to offset 1 lets
  // the closest hit overwrite any farther one, so no early exit is needed
  always_comb begin
    o_grant = {PTR_W{1'b0}};
    o_any   = 1'b0;
    w_sum   = {SUM_W{1'b0}};
    w_idx   = {PTR_W{1'b0}};
    for (int k = N_REQ; k >= 1; k--) begin
      w_sum   = {1'b0, i_ptr} + SUM_W'(k);
      w_sum   = (w_sum >= SUM_W'(N_REQ)) ? (w_sum - SUM_W'(N_REQ)) : w_sum;
      w_idx   = w_sum[PTR_W-1:0];
      o_grant = i_req[w_idx] ? w_idx : o_grant;
      o_any   = o_any | i_req[w_idx];
    end
  end

endmodule

// File: rtl/coldata_i2c_sched.sv
// -----------------------------------------------------------------------------
// coldata_i2c_sched
// Round-robin scheduler sharing one coldata_i2c engine between N_REQ
// requesters in the clk62p5 domain. One frame per transaction; the engine is
// given a level start, the scheduler waits for done or a timeout, returns the
// readback byte and status to the granted requester and then keeps start low
// for a minimum idle gap.
// Ports:
//   clk62p5, aresetn          clock, asynchronous active-low reset
//   req_valid/req_frame       per-requester level request and frame
//   req_ready                 one-cycle accept pulse to the granted requester
//   rsp_valid/data/status     one-cycle completion pulse, byte and status
//   busy                      high while a transaction (ARB..GAP) is active
//   i2c_frame/i2c_start       frame and level start towards the engine
//   i2c_done/rdata/ack_err    engine completion, readback byte, nack flag
// -----------------------------------------------------------------------------
module coldata_i2c_sched
  import coldata_i2c_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4096,
  parameter int GAP     = 8,
  parameter int FRAME_W = coldata_i2c_pkg::FRAME_W
) (
  input  logic                     clk62p5,
  input  logic                     aresetn,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*FRAME_W-1:0] req_frame,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [7:0]               rsp_data,
  output logic [1:0]               rsp_status,
  output logic                     busy,
  output logic [FRAME_W-1:0]       i2c_frame,
  output logic                     i2c_start,
  input  logic                     i2c_done,
  input  logic [7:0]               i2c_rdata,
  input  logic                     i2c_ack_err
);

  localparam int PTR_W  = idx_w(N_REQ);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam int GCNT_W = $clog2(GAP + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [GCNT_W-1:0] GCNT_LOAD = GCNT_W'(GAP - 1);

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  state_t             r_state;
  state_t             w_next;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_grant;
  logic [PTR_W-1:0]   w_grant;
  logic               w_any;
  logic [FRAME_W-1:0] w_sel_frame;
  logic [N_REQ-1:0]   w_req_oh;
  logic [N_REQ-1:0]   w_rsp_oh;
  logic               w_tmo;
  logic [TCNT_W-1:0]  r_tcnt;
  logic [GCNT_W-1:0]  r_gcnt;
  logic [FRAME_W-1:0] r_frame;
  logic               r_start;
  logic               r_busy;
  logic [N_REQ-1:0]   r_req_ready;
  logic [N_REQ-1:0]   r_rsp_valid;
  logic [7:0]         r_rsp_data;
  logic [1:0]         r_rsp_status;

  // Reset synchroniser: assertion reaches every flop at once, release is
  // aligned to clk62p5 two edges later
  always_ff @(posedge clk62p5 or negedge aresetn) begin
    if (!aresetn) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  coldata_i2c_rr_arb #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  // Frame of the requester currently winning arbitration
  always_comb begin
    w_sel_frame = {FRAME_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      w_sel_frame = (w_grant == PTR_W'(i)) ? req_frame[i*FRAME_W +: FRAME_W] : w_sel_frame;
    end
  end

  assign w_req_oh = N_REQ'(1'b1) << w_grant;
  assign w_rsp_oh = N_REQ'(1'b1) << r_grant;
  assign w_tmo    = (r_tcnt == TCNT_LAST);

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = (|req_valid) ? S_ARB : S_IDLE;
      // A requester may withdraw before the grant; nothing left means idle
      S_ARB:   w_next = w_any ? S_START : S_IDLE;
      S_START: w_next = S_WAIT;
      S_WAIT:  w_next = (i2c_done || w_tmo) ? S_RESP : S_WAIT;
      S_RESP:  w_next = S_GAP;
      // Pending work at gap exit skips the idle cycle
      S_GAP:   w_next = (r_gcnt != {GCNT_W{1'b0}}) ? S_GAP :
                        ((|req_valid) ? S_ARB : S_IDLE);
      default: w_next = S_IDLE;
    endcase
  end

  // State register, counters, grant/frame latches and all registered outputs
  always_ff @(posedge clk62p5 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= PTR_W'(N_REQ - 1);
      r_grant      <= {PTR_W{1'b0}};
      r_tcnt       <= {TCNT_W{1'b0}};
      r_gcnt       <= {GCNT_W{1'b0}};
      r_frame      <= {FRAME_W{1'b0}};
      r_start      <= 1'b0;
      r_busy       <= 1'b0;
      r_req_ready  <= {N_REQ{1'b0}};
      r_rsp_valid  <= {N_REQ{1'b0}};
      r_rsp_data   <= 8'h00;
      r_rsp_status <= ST_OK;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next != S_IDLE);
      r_req_ready <= {N_REQ{1'b0}};
      r_rsp_valid <= {N_REQ{1'b0}};
      case (r_state)
        S_ARB: begin
          if (w_any) begin
            r_req_ready <= w_req_oh;
            r_frame     <= w_sel_frame;
            r_ptr       <= w_grant;
            r_grant     <= w_grant;
          end
        end
        S_START: begin
          r_start <= 1'b1;
          r_tcnt  <= {TCNT_W{1'b0}};
        end
        S_WAIT: begin
          r_tcnt <= r_tcnt + TCNT_W'(1);
          // Start drops on the edge into RESP, so it is high only for the
          // WAIT cycles; done is tested first so it wins over expiry
          if (i2c_done) begin
            r_start      <= 1'b0;
            r_rsp_valid  <= w_rsp_oh;
            r_rsp_data   <= i2c_rdata;
            r_rsp_status <= done_status(i2c_ack_err);
          end else if (w_tmo) begin
            r_start      <= 1'b0;
            r_rsp_valid  <= w_rsp_oh;
            r_rsp_data   <= 8'h00;
            r_rsp_status <= ST_TIMEOUT;
          end
        end
        S_RESP: begin
          r_start <= 1'b0;
          r_gcnt  <= GCNT_LOAD;
        end
        S_GAP: begin
          if (r_gcnt != {GCNT_W{1'b0}}) begin
            r_gcnt <= r_gcnt - GCNT_W'(1);
          end
        end
        default: begin
          r_start <= r_start;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_status = r_rsp_status;
  assign busy       = r_busy;
  assign i2c_frame  = r_frame;
  assign i2c_start  = r_start;

endmodule

// File: tb/tb_coldata_i2c_sched.sv
// -----------------------------------------------------------------------------
// tb_coldata_i2c_sched
// Directed bench for coldata_i2c_sched: a scripted engine answers i2c_start,
// expected responses are queued when each transaction is launched and popped
// by a monitor when rsp_valid pulses.
// -----------------------------------------------------------------------------
module tb_coldata_i2c_sched;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 4096;
  localparam int GAP     = 8;
  localparam int FW      = 27;

  logic                clk62p5 = 1'b0;
  logic                aresetn;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*FW-1:0] req_frame;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    rsp_valid;
  logic [7:0]          rsp_data;
  logic [1:0]          rsp_status;
  logic                busy;
  logic [FW-1:0]       i2c_frame;
  logic                i2c_start;
  logic                i2c_done;
  logic [7:0]          i2c_rdata;
  logic                i2c_ack_err;

  logic [FW-1:0] fr [N_REQ];
  assign req_frame = {fr[3], fr[2], fr[1], fr[0]};

  typedef struct packed {
    logic [3:0] oh;
    logic [7:0] data;
    logic [1:0] st;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  coldata_i2c_sched #(
    .N_REQ   (N_REQ),
    .TIMEOUT (TIMEOUT),
    .GAP     (GAP),
    .FRAME_W (FW)
  ) dut (
    .clk62p5     (clk62p5),
    .aresetn     (aresetn),
    .req_valid   (req_valid),
    .req_frame   (req_frame),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_status  (rsp_status),
    .busy        (busy),
    .i2c_frame   (i2c_frame),
    .i2c_start   (i2c_start),
    .i2c_done    (i2c_done),
    .i2c_rdata   (i2c_rdata),
    .i2c_ack_err (i2c_ack_err)
  );

  always #5 clk62p5 = ~clk62p5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation
  always @(negedge clk62p5) begin
    if (rsp_valid !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_onehot", 32'(rsp_valid), 32'(mon_e.oh));
        chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        chk("rsp_status", 32'(rsp_status), 32'(mon_e.st));
      end
    end
  end

  // Count negedges until req_ready pulses (bounded)
  task automatic wait_ready(output int n);
    n = 0;
    while (req_ready === 4'b0000 && n < 100) begin
      @(negedge clk62p5);
      n++;
    end
    chk("ready_within_bound", 32'(n < 100), 32'd1);
  endtask

  // Engine model: raise done dly cycles into WAIT, then expect rsp next cycle
  task automatic engine(input int dly, input logic [7:0] rd, input logic ack,
                        input logic [3:0] oh);
    int n;
    n = 0;
    while (i2c_start !== 1'b1 && n < 50) begin
      @(negedge clk62p5);
      n++;
    end
    chk("start_seen", 32'(i2c_start), 32'd1);
    repeat (dly) @(negedge clk62p5);
    i2c_rdata   = rd;
    i2c_ack_err = ack;
    i2c_done    = 1'b1;
    @(negedge clk62p5);
    i2c_done    = 1'b0;
    chk("done_to_rsp", 32'(rsp_valid), 32'(oh));
    chk("start_low_in_resp", 32'(i2c_start), 32'd0);
  endtask

  // Called on the RESP cycle: GAP cycles of low start / busy, then idle
  task automatic check_gap();
    for (int i = 0; i < GAP; i++) begin
      @(negedge clk62p5);
      chk("gap_start_low", 32'(i2c_start), 32'd0);
      chk("gap_busy", 32'(busy), 32'd1);
    end
    @(negedge clk62p5);
    chk("idle_after_gap", 32'(busy), 32'd0);
  endtask

  initial begin
    int            n;
    logic [FW-1:0] saved;
    logic [7:0]    d;
    aresetn     = 1'b0;
    req_valid   = 4'b0000;
    i2c_done    = 1'b0;
    i2c_rdata   = 8'h00;
    i2c_ack_err = 1'b0;
    fr[0] = 27'b10101010_0_11110000_0_10101010_0;
    fr[1] = 27'h1234567;
    fr[2] = 27'h2ABCDEF;
    fr[3] = 27'h0F0F0F1;

    // Reset state
    repeat (3) @(negedge clk62p5);
    chk("rst_start", 32'(i2c_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_status", 32'(rsp_status), 32'd0);
    chk("rst_frame", 32'(i2c_frame), 32'd0);
    aresetn = 1'b1;
    repeat (3) @(negedge clk62p5);

    // Single request, done after 40 cycles, frame may change after accept
    req_valid = 4'b0001;
    wait_ready(n);
    chk("req_to_ready", 32'(n), 32'd2);
    chk("single_grant", 32'(req_ready), 32'd1);
    chk("single_frame", 32'(i2c_frame), 32'(fr[0]));
    req_valid = 4'b0000;
    saved = fr[0];
    fr[0] = ~saved;
    exp_q.push_back({4'b0001, 8'hA5, 2'b00});
    engine(40, 8'hA5, 1'b0, 4'b0001);
    chk("frame_hold", 32'(i2c_frame), 32'(saved));
    fr[0] = saved;
    check_gap();

    // Nack
    req_valid = 4'b0001;
    wait_ready(n);
    req_valid = 4'b0000;
    exp_q.push_back({4'b0001, 8'h3C, 2'b01});
    engine(7, 8'h3C, 1'b1, 4'b0001);
    check_gap();

    // Done while idle is ignored
    i2c_done = 1'b1;
    repeat (2) begin
      @(negedge clk62p5);
      chk("stray_done_busy", 32'(busy), 32'd0);
      chk("stray_done_rsp", 32'(rsp_valid), 32'd0);
    end
    i2c_done = 1'b0;

    // Done on the last counter value wins over expiry
    req_valid = 4'b0001;
    wait_ready(n);
    req_valid = 4'b0000;
    exp_q.push_back({4'b0001, 8'h5A, 2'b00});
    engine(TIMEOUT - 1, 8'h5A, 1'b0, 4'b0001);
    check_gap();

    // Timeout from requester 1 (next in line after 0)
    req_valid = 4'b0010;
    wait_ready(n);
    chk("tmo_grant", 32'(req_ready), 32'd2);
    req_valid = 4'b0000;
    i2c_rdata = 8'hFF;
    exp_q.push_back({4'b0010, 8'h00, 2'b10});
    n = 0;
    while (i2c_start !== 1'b1 && n < 50) begin
      @(negedge clk62p5);
      n++;
    end
    n = 0;
    while (i2c_start === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk62p5);
    end
    chk("tmo_start_cycles", 32'(n), 32'(TIMEOUT));
    chk("tmo_rsp_pulse", 32'(rsp_valid), 32'd2);
    check_gap();

    // Reset while requester 2 is in WAIT
    req_valid = 4'b0100;
    wait_ready(n);
    chk("rst_case_grant", 32'(req_ready), 32'd4);
    req_valid = 4'b0000;
    n = 0;
    while (i2c_start !== 1'b1 && n < 50) begin
      @(negedge clk62p5);
      n++;
    end
    chk("rst_case_start_high", 32'(i2c_start), 32'd1);
    repeat (5) @(negedge clk62p5);
    aresetn = 1'b0;
    #1;
    chk("midrst_start", 32'(i2c_start), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    chk("midrst_rsp", 32'(rsp_valid), 32'd0);
    repeat (3) @(negedge clk62p5);
    aresetn = 1'b1;

    // Fairness with all requesters continuously valid; first grant is 0
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      wait_ready(n);
      if (i > 0) begin
        chk("b2b_resp_to_ready", 32'(n), 32'd10);
      end
      chk("fair_grant", 32'(req_ready), 32'd1 << (i % 4));
      chk("fair_frame", 32'(i2c_frame), 32'(fr[i % 4]));
      d = 8'(8'h10 + i);
      exp_q.push_back({4'(4'b0001 << (i % 4)), d, 2'b00});
      engine(5, d, 1'b0, 4'(4'b0001 << (i % 4)));
      if (i == 7) begin
        req_valid = 4'b0000;
      end
    end
    check_gap();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coldata_i2c_sched.md
Name: coldata_i2c_sched

Overview:
- Round-robin scheduler that shares one coldata_i2c engine between N_REQ requesters (AXI software port, power-up config sequencer, latency-calibration logic, ...).
- Accepts one 27-bit frame per transaction: three bytes, each followed by an ack slot, MSB first.
- Drives the engine's level-type start, waits for done or timeout, and returns readback byte and status to the granted requester.
- Enforces a minimum idle gap between frames.
- Sits between requesters and the coldata_i2c core in the clk62p5 domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 4096, clk62p5 cycles allowed from start assertion to engine done.
- GAP, 8, cycles start is held low between transactions (≥2).
- FRAME_W, 27, frame width.

Ports:
- clk62p5  in  1  block clock; single clock domain.
- aresetn  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request, level; held until req_ready.
- req_frame  in  N_REQ*FRAME_W  per-requester frames, requester i at bits [i*FRAME_W +: FRAME_W].
- req_ready  out  N_REQ  one-cycle accept pulse to the granted requester.
- rsp_valid  out  N_REQ  one-cycle completion pulse to the granted requester.
- rsp_data  out  8  readback byte, valid with rsp_valid.
- rsp_status  out  2  00 ok, 01 nack (ack_err), 10 timeout; valid with rsp_valid.
- busy  out  1  high from ARB through GAP.
- i2c_frame  out  FRAME_W  frame to the engine.
- i2c_start  out  1  level start to the engine.
- i2c_done  in  1  engine done, level or pulse; sampled only in WAIT.
- i2c_rdata  in  8  engine readback byte.
- i2c_ack_err  in  1  engine nack flag, valid with i2c_done.

Behaviour:
- Reset (async assert, sync deassert internally): all outputs 0; state IDLE; rr pointer = N_REQ-1, so requester 0 has first priority.
- Reset mid-transaction drops i2c_start combinationally with reset assertion and loses the in-flight response.
- States:
  - IDLE: if any req_valid, go to ARB next cycle.
  - ARB (1 cycle): grant the first asserted req_valid searching from ptr+1 mod N_REQ. Pulse req_ready[g]. Latch req_frame[g] into i2c_frame. ptr <= g. Go to START.
  - START: i2c_start <= 1; clear the timeout counter; go to WAIT.
  - WAIT: i2c_start stays 1; counter increments each cycle.
    - i2c_done = 1: latch i2c_rdata; status = ack_err ? 01 : 00.
    - Else if counter == TIMEOUT-1: status = 10, rsp_data = 0.
    - Either case: go to RESP.
    - If done and the timeout expiry coincide, done wins.
  - RESP (1 cycle): i2c_start <= 0; pulse rsp_valid[g] with rsp_data/rsp_status stable; load gap counter; go to GAP.
  - GAP: start held low for GAP cycles, then IDLE. A request pending at exit goes directly to ARB with no IDLE cycle.
- Latency:
  - Request to req_ready: 2 cycles from IDLE.
  - i2c_done to rsp_valid: 1 cycle.
  - i2c_start is never high for more than TIMEOUT+1 cycles.
- i2c_frame holds its value from ARB until the next ARB; a requester may change req_frame after req_ready.
- req_valid dropped by a requester before grant: no error, simply not granted.
- rsp_data and rsp_status hold their values until the next RESP.
- Any i2c_done seen outside WAIT is ignored.
- Fairness: with all requesters continuously valid, grants go 0,1,2,3,0,... No requester waits more than N_REQ-1 transactions.

Decomposition:
- Shared package coldata_i2c_pkg:
  - FRAME_W constant.
  - Status codes ST_OK=2'b00, ST_NACK=2'b01, ST_TIMEOUT=2'b10.
  - State enum {IDLE, ARB, START, WAIT, RESP, GAP}.
- One sub-module, coldata_i2c_rr_arb: combinational round-robin priority pick.
  - Inputs: req vector, ptr.
  - Outputs: grant index, any.
- FSM, counters and latches live in the top.

Test Plan:
- Single request: req 0 with frame 27'b10101010_0_11110000_0_10101010_0; engine returns done 40 cycles after start with rdata=0xA5, ack_err=0 -> req_ready[0] at cycle 2; i2c_frame equals the frame; rsp_valid[0] one cycle after done; rsp_data=0xA5; status 00; start low for 8 cycles after.
- Nack: engine raises done with ack_err=1, rdata=0x3C -> rsp_status=01, rsp_data=0x3C.
- Timeout: engine never raises done -> start high for exactly 4096 cycles; rsp_status=10, rsp_data=0x00; start then low for GAP cycles.
- Fairness: all four req_valid held for 8 transactions -> grant order 0,1,2,3,0,1,2,3; each rsp_valid matches its own grant.
- Done on the timeout cycle: done asserted on counter 4095 -> status 00, not 10.
- Reset mid-WAIT: aresetn low 3 cycles while start is high -> start, busy and all pulses 0 immediately; first post-reset grant goes to requester 0.
